note_sequencer: RTL

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// Chart-driven note sequencer: walks a ROM of {lane mask, duration} entries and
// presents each mask for duration*TICK_DIV clocks. NOTE_SEQ_LOOP_EN makes the song repeat.
module note_sequencer #(
    parameter int TICK_DIV = 12500000,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [4:0]        notes_to_play,
    output logic              note_valid,
    output logic              song_done,
    output logic              busy
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0]     TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, HOLD, DONE} state_t;
    state_t state, state_nx;

    logic [10:0]   dur_cnt;
    logic [TW-1:0] tick_cnt;
    logic          valid_pend;
    logic [4:0]    rom_mask;
    logic [10:0]   rom_dur;
    logic          do_start, do_load, do_adv, note_end, wrap, last_addr;

    assign rom_mask = rom_data[15:11];
    assign rom_dur  = rom_data[10:0];
    assign busy     = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_start  = 1'b0;
        do_load   = 1'b0;
        do_adv    = 1'b0;
        note_end  = 1'b0;
        wrap      = 1'b0;
        last_addr = (rom_addr == ADDR_MAX);
        case (state)
            IDLE, DONE: if (start) begin
                state_nx = FETCH;
                do_start = 1'b1;
            end
            FETCH: state_nx = WAIT;
            WAIT:  state_nx = LOAD;
            LOAD: begin
                if (rom_dur == 11'd0) begin
`ifdef NOTE_SEQ_LOOP_EN
                    wrap     = 1'b1;
                    state_nx = FETCH;
`else
                    state_nx = DONE;
`endif
                end else begin
                    do_load  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: if (!pause) begin
                do_adv = 1'b1;
                if (tick_cnt == TICK_MAX && dur_cnt <= 11'd1) begin
                    note_end = 1'b1;
                    if (!last_addr) state_nx = FETCH;
                    else begin
`ifdef NOTE_SEQ_LOOP_EN
                        wrap     = 1'b1;
                        state_nx = FETCH;
`else
                        state_nx = DONE;
`endif
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // stop outranks every other request in the same cycle
        if (stop) begin
            state_nx = IDLE;
            do_start = 1'b0;
            do_load  = 1'b0;
            do_adv   = 1'b0;
            note_end = 1'b0;
            wrap     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr      <= '0;
            notes_to_play <= '0;
            note_valid    <= 1'b0;
            valid_pend    <= 1'b0;
            song_done     <= 1'b0;
            dur_cnt       <= '0;
            tick_cnt      <= '0;
        end else if (stop) begin
            rom_addr      <= '0;
            notes_to_play <= '0;
            note_valid    <= 1'b0;
            valid_pend    <= 1'b0;
            song_done     <= 1'b0;
            dur_cnt       <= '0;
            tick_cnt      <= '0;
        end else begin
            // note_valid trails the mask update by one clock
            valid_pend <= do_load;
            note_valid <= valid_pend;
            if (do_start) begin
                rom_addr <= '0;
                dur_cnt  <= '0;
                tick_cnt <= '0;
            end
            if (do_load) begin
                notes_to_play <= rom_mask;
                dur_cnt       <= rom_dur;
                tick_cnt      <= '0;
            end
            if (do_adv) begin
                if (tick_cnt == TICK_MAX) begin
                    tick_cnt <= '0;
                    dur_cnt  <= dur_cnt - 11'd1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
            if (note_end && !last_addr) rom_addr <= rom_addr + 1'b1;
            if (wrap) rom_addr <= '0;
            if (state == DONE) notes_to_play <= '0;
`ifdef NOTE_SEQ_LOOP_EN
            song_done <= wrap;
`else
            song_done <= (state == DONE) && (state_nx == DONE);
`endif
        end
    end
endmodule
